pc_fetch: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined CPU. It holds the program counter, issues word reads to the shared instruction/data RAM, and presents each fetched instruction with its address to the IF/ID pipeline register. It honours pipeline stalls from the hazard unit, branch redirects from ID, and structural stalls while the MEM stage owns the RAM. On all non-delivery cycles it emits a NOP bubble.

---
 rtl/pc_fetch_pkg.sv | 16 +
 rtl/pc_fetch_hold_buf.sv | 29 ++
 rtl/pc_fetch.sv | 121 ++++++++++++
 tb/tb_pc_fetch.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and defaults for the instruction-fetch stage
package pc_fetch_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } pf_state_e;

endpackage

// File: rtl/pc_fetch_hold_buf.sv
// rtl/pc_fetch_hold_buf.sv - one-entry buffer for an instruction fetched while IF/ID is stalled
module pc_fetch_hold_buf
  import pc_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              buf_valid,
  output logic [WORD_W-1:0] buf_instr,
  output logic [ADDR_W-1:0] buf_addr
);

  // clear wins over load so a redirect never leaves a stale entry behind
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      buf_valid <= 1'b0;
      buf_instr <= '0;
      buf_addr  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_instr <= load_instr;
      buf_addr  <= load_addr;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction fetch into IF/ID
// Optional stalled-ack hold buffer enabled by PC_FETCH_HOLD_BUF_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              pfi_clk,
  input  logic              pfi_rst,
  input  logic              pfi_stall,
  input  logic              pfi_br_en,
  input  logic [ADDR_W-1:0] pfi_br_addr,
  input  logic              pfi_mem_busy,
  output logic              pfo_mem_req,
  output logic [ADDR_W-1:0] pfo_mem_addr,
  input  logic              pfi_mem_ack,
  input  logic [WORD_W-1:0] pfi_mem_rdata,
  output logic              pfo_valid,
  output logic [ADDR_W-1:0] pfo_addr,
  output logic [WORD_W-1:0] pfo_instr
);

  pf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              ack_e;

`ifdef PC_FETCH_HOLD_BUF_EN
  logic              buf_load, buf_clear, buf_valid;
  logic [WORD_W-1:0] buf_instr;
  logic [ADDR_W-1:0] buf_addr;

  pc_fetch_hold_buf u_hold_buf (
    .clk        (pfi_clk),
    .rst        (pfi_rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (pfi_mem_rdata),
    .load_addr  (pc),
    .buf_valid  (buf_valid),
    .buf_instr  (buf_instr),
    .buf_addr   (buf_addr)
  );
`endif

  assign pfo_mem_addr = pc;

  always_ff @(posedge pfi_clk) begin
    if (!pfi_rst) begin
      state <= S_RST;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pfo_valid = 1'b0;
    pfo_instr = NOP_INSTR;
    pfo_addr  = pc;
`ifdef PC_FETCH_HOLD_BUF_EN
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    pfo_mem_req = pfi_rst && (state == S_FETCH) && !pfi_mem_busy;
`else
    // without a buffer a stalled ack would be lost, so do not ask at all
    pfo_mem_req = pfi_rst && (state == S_FETCH) && !pfi_mem_busy && !pfi_stall;
`endif
    ack_e = pfi_mem_ack && pfo_mem_req;

    if (pfi_br_en) begin
      state_nxt = S_FETCH;
      pc_nxt    = pfi_br_addr;
`ifdef PC_FETCH_HOLD_BUF_EN
      buf_clear = 1'b1;
`endif
    end else begin
      case (state)
        S_RST: state_nxt = S_FETCH;
        S_FETCH: begin
          if (ack_e && !pfi_stall) begin
            pfo_valid = 1'b1;
            pfo_instr = pfi_mem_rdata;
            pc_nxt    = pc + 1'b1;
          end
`ifdef PC_FETCH_HOLD_BUF_EN
          else if (ack_e) begin
            buf_load  = 1'b1;
            state_nxt = S_HOLD;
          end
`endif
        end
        S_HOLD: begin
`ifdef PC_FETCH_HOLD_BUF_EN
          pfo_valid = buf_valid;
          pfo_instr = buf_instr;
          pfo_addr  = buf_addr;
          if (!pfi_stall) begin
            pc_nxt    = buf_addr + 1'b1;
            buf_clear = 1'b1;
            state_nxt = S_FETCH;
          end
`else
          state_nxt = S_FETCH;
`endif
        end
        default: state_nxt = S_RST;
      endcase
    end

    if (!pfi_rst) begin
      pfo_valid = 1'b0;
      pfo_instr = NOP_INSTR;
      pfo_addr  = pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed and random checking of pc_fetch against a cycle reference model
module tb_pc_fetch;

`ifdef PC_FETCH_HOLD_BUF_EN
  localparam bit HBUF = 1'b1;
`else
  localparam bit HBUF = 1'b0;
`endif
  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        pfi_rst = 1'b0, pfi_stall = 1'b0, pfi_br_en = 1'b0;
  logic [15:0] pfi_br_addr = '0;
  logic        pfi_mem_busy = 1'b0, pfi_mem_ack = 1'b0;
  logic [15:0] pfi_mem_rdata = '0;
  logic        pfo_mem_req, pfo_valid;
  logic [15:0] pfo_mem_addr, pfo_addr, pfo_instr;

  always #5 clk = ~clk;

  pc_fetch dut (
    .pfi_clk       (clk),
    .pfi_rst       (pfi_rst),
    .pfi_stall     (pfi_stall),
    .pfi_br_en     (pfi_br_en),
    .pfi_br_addr   (pfi_br_addr),
    .pfi_mem_busy  (pfi_mem_busy),
    .pfo_mem_req   (pfo_mem_req),
    .pfo_mem_addr  (pfo_mem_addr),
    .pfi_mem_ack   (pfi_mem_ack),
    .pfi_mem_rdata (pfi_mem_rdata),
    .pfo_valid     (pfo_valid),
    .pfo_addr      (pfo_addr),
    .pfo_instr     (pfo_instr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model: program counter, "just out of reset" flag, optional held instruction
  logic [15:0] m_pc = RPC;
  bit          m_fresh = 1'b1;
  bit          m_held = 1'b0;
  logic [15:0] m_h_instr = '0, m_h_addr = '0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  task automatic step(input bit r, input bit s, input bit b, input logic [15:0] ba,
                      input bit bz, input bit a);
    bit          e_req, ack_e, e_valid;
    logic [15:0] e_addr, e_instr;
    @(negedge clk);
    pfi_rst = r; pfi_stall = s; pfi_br_en = b; pfi_br_addr = ba;
    pfi_mem_busy = bz; pfi_mem_ack = a; pfi_mem_rdata = memf(m_pc);
    #1;
    e_req   = r && !m_fresh && !m_held && !bz && (HBUF || !s);
    ack_e   = a && e_req;
    e_valid = 1'b0;
    e_instr = NOP;
    e_addr  = m_pc;
    if (r && !b) begin
      if (m_held) begin
        e_valid = 1'b1; e_instr = m_h_instr; e_addr = m_h_addr;
      end else if (ack_e && !s) begin
        e_valid = 1'b1; e_instr = memf(m_pc);
      end
    end
    check("mem_req",  16'(pfo_mem_req), 16'(e_req));
    check("mem_addr", pfo_mem_addr, m_pc);
    check("valid",    16'(pfo_valid), 16'(e_valid));
    check("instr",    pfo_instr, e_instr);
    check("addr",     pfo_addr, e_addr);
    if (!r) begin
      m_pc = RPC; m_fresh = 1'b1; m_held = 1'b0;
    end else if (b) begin
      m_pc = ba; m_fresh = 1'b0; m_held = 1'b0;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (m_held) begin
      if (!s) begin
        m_pc = m_h_addr + 16'd1; m_held = 1'b0;
      end
    end else if (ack_e) begin
      if (!s) m_pc = m_pc + 16'd1;
      else if (HBUF) begin
        m_held = 1'b1; m_h_instr = memf(m_pc); m_h_addr = m_pc;
      end
    end
    cyc++;
  endtask

  initial begin
    bit          r, s, b, bz, a;
    logic [15:0] ba;
    @(posedge clk);
    // reset held for 3 cycles with memory always acking
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0, 0, 1);
    // two wait states per instruction
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 16'h0, 0, 0);
      step(1, 0, 0, 16'h0, 0, 0);
      step(1, 0, 0, 16'h0, 0, 1);
    end
    // stall at ack
    step(1, 0, 1, 16'h0010, 0, 0);
    step(1, 1, 0, 16'h0, 0, 1);
    step(1, 1, 0, 16'h0, 0, 1);
    step(1, 1, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 0, 1);
    // branch during a pending request with a same-cycle ack
    step(1, 0, 1, 16'h0020, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 1, 16'h0100, 0, 1);
    step(1, 0, 0, 16'h0, 0, 1);
    // structural stall with ack forced high
    step(1, 0, 0, 16'h0, 1, 1);
    step(1, 0, 0, 16'h0, 1, 1);
    step(1, 0, 0, 16'h0, 0, 1);
    // wrap past 0xFFFF
    step(1, 0, 1, 16'hFFFE, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0, 0, 1);
    // reset while holding
    step(1, 0, 1, 16'h0040, 0, 0);
    step(1, 1, 0, 16'h0, 0, 1);
    step(1, 1, 0, 16'h0, 0, 1);
    step(0, 1, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) >= 3);
      b  = ($urandom_range(99) < 8);
      s  = ($urandom_range(99) < 25);
      bz = ($urandom_range(99) < 20);
      a  = ($urandom_range(99) < 60);
      case ($urandom_range(7))
        0: ba = 16'hFFFF;
        1: ba = 16'hFFFE;
        2: ba = 16'h0000;
        default: ba = 16'($urandom);
      endcase
      step(r, s, b, ba, bz, a);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
